// File: rtl/uart_bcd_msg_sequencer_pkg.sv
// Shared types and ASCII constants for the BCD-to-UART line sequencer.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S_D1 = 3'd1,
    S_D0 = 3'd2,
    S_CR = 3'd3,
    S_LF = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_QMARK    = 8'h3F;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  // No valid BCD pair encodes to this, so the first line after reset is always sent.
  localparam logic [7:0] LAST_SENT_INIT = 8'hFF;

endpackage

// File: rtl/uart_bcd_msg_sequencer_bcd_to_ascii.sv
// Combinational BCD digit to ASCII; non-decimal nibbles render as '?'.
module bcd_to_ascii
  import uart_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [7:0] o_ascii
);

  // Decimal digits map onto '0'..'9', anything else is flagged visibly.
  always_comb begin
    if (i_digit <= 4'd9) begin
      o_ascii = ASCII_ZERO + {4'd0, i_digit};
    end else begin
      o_ascii = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/uart_bcd_msg_sequencer.sv
// Formats a two-digit BCD value as "D1 D0 CR LF" and streams it over a
// valid/ready byte handshake whenever the value changes or a repeat timer expires.
module uart_bcd_msg_sequencer
  import uart_seq_pkg::*;
#(
  parameter int REPEAT_CYCLES = 0,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       msg_done
);

  localparam bit              REP_EN  = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] REP_MAX = REP_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  state_e           r_state;
  state_e           w_state_nx;
  logic [7:0]       r_snap;
  logic [7:0]       r_last_sent;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_cnt_nx;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic             r_busy;
  logic             r_msg_done;
  logic             w_tx_valid_nx;
  logic [7:0]       w_tx_data_nx;
  logic             w_msg_done_nx;
  logic             w_load;
  logic             w_trigger;
  logic [7:0]       w_pair;
  logic [3:0]       w_digit;
  logic [7:0]       w_ascii;

  assign w_pair    = {bcd1, bcd0};
  assign w_trigger = (w_pair != r_last_sent) || (REP_EN && (r_rep_cnt == REP_MAX));
  // In IDLE the high digit is encoded straight from the input (it is snapped on
  // the same edge); afterwards only the low digit of the snapshot is needed.
  assign w_digit   = (r_state == IDLE) ? bcd1 : r_snap[3:0];

  bcd_to_ascii u_bcd_to_ascii (
    .i_digit (w_digit),
    .o_ascii (w_ascii)
  );

  // Next-state and next-output logic; outputs hold while the byte is not taken.
  always_comb begin
    w_state_nx    = r_state;
    w_tx_valid_nx = r_tx_valid;
    w_tx_data_nx  = r_tx_data;
    w_msg_done_nx = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trigger) begin
          w_state_nx    = S_D1;
          w_tx_valid_nx = 1'b1;
          w_tx_data_nx  = w_ascii;
          w_load        = 1'b1;
        end else begin
          w_tx_valid_nx = 1'b0;
          w_tx_data_nx  = 8'h00;
        end
      end
      S_D1: begin
        if (tx_ready) begin
          w_state_nx   = S_D0;
          w_tx_data_nx = w_ascii;
        end else begin
          w_state_nx   = S_D1;
        end
      end
      S_D0: begin
        if (tx_ready) begin
          w_state_nx   = S_CR;
          w_tx_data_nx = ASCII_CR;
        end else begin
          w_state_nx   = S_D0;
        end
      end
      S_CR: begin
        if (tx_ready) begin
          w_state_nx   = S_LF;
          w_tx_data_nx = ASCII_LF;
        end else begin
          w_state_nx   = S_CR;
        end
      end
      S_LF: begin
        if (tx_ready) begin
          w_state_nx    = IDLE;
          w_tx_valid_nx = 1'b0;
          w_tx_data_nx  = 8'h00;
          w_msg_done_nx = 1'b1;
        end else begin
          w_state_nx    = S_LF;
        end
      end
      default: begin
        w_state_nx    = IDLE;
        w_tx_valid_nx = 1'b0;
        w_tx_data_nx  = 8'h00;
      end
    endcase
  end

  // Repeat timer counts idle cycles and restarts whenever a line begins.
  always_comb begin
    w_rep_cnt_nx = r_rep_cnt;
    if (!REP_EN) begin
      w_rep_cnt_nx = '0;
    end else if ((r_state != IDLE) || w_trigger) begin
      w_rep_cnt_nx = '0;
    end else if (r_rep_cnt < REP_MAX) begin
      w_rep_cnt_nx = r_rep_cnt + CNT_W'(1);
    end else begin
      w_rep_cnt_nx = r_rep_cnt;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_snap      <= 8'h00;
      r_last_sent <= LAST_SENT_INIT;
      r_rep_cnt   <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_msg_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_rep_cnt  <= w_rep_cnt_nx;
      r_tx_valid <= w_tx_valid_nx;
      r_tx_data  <= w_tx_data_nx;
      r_busy     <= (w_state_nx != IDLE);
      r_msg_done <= w_msg_done_nx;
      if (w_load) begin
        r_snap      <= w_pair;
        r_last_sent <= w_pair;
      end else begin
        r_snap      <= r_snap;
        r_last_sent <= r_last_sent;
      end
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign msg_done = r_msg_done;

endmodule

// File: tb/tb_uart_bcd_msg_sequencer.sv
// Scoreboard bench: one instance without periodic re-send, one with REPEAT_CYCLES=20.
module tb_uart_bcd_msg_sequencer;

  logic       clk = 1'b0;
  logic       rst, rst_r;
  logic [3:0] bcd0, bcd1, bcd0_r, bcd1_r;
  logic       tx_ready, tx_ready_r;
  logic       tx_valid, busy, msg_done;
  logic       tx_valid_r, busy_r, msg_done_r;
  logic [7:0] tx_data, tx_data_r;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rq[$];
  logic       prev_v_r = 1'b0;
  bit         have_done = 1'b0;
  int         done_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_bcd_msg_sequencer dut (
    .clk(clk), .rst(rst), .bcd0(bcd0), .bcd1(bcd1), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy), .msg_done(msg_done)
  );

  uart_bcd_msg_sequencer #(.REPEAT_CYCLES(20), .CNT_W(24)) dut_rep (
    .clk(clk), .rst(rst_r), .bcd0(bcd0_r), .bcd1(bcd1_r), .tx_ready(tx_ready_r),
    .tx_valid(tx_valid_r), .tx_data(tx_data_r), .busy(busy_r), .msg_done(msg_done_r)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] exp_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'd0, d}) : 8'h3F;
  endfunction

  task automatic push_line(input int which, input logic [3:0] d1, input logic [3:0] d0);
    logic [7:0] line[4];
    line[0] = exp_ascii(d1);
    line[1] = exp_ascii(d0);
    line[2] = 8'h0D;
    line[3] = 8'h0A;
    for (int i = 0; i < 4; i++) begin
      if (which == 0) exp_q.push_back(line[i]);
      else            exp_rq.push_back(line[i]);
    end
  endtask

  task automatic wait_done(input int which, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0) ? msg_done : msg_done_r) begin
        seen = 1'b1;
        check_val({tag, "_busy"}, 32'((which == 0) ? busy : busy_r), 32'd0);
      end
    end
    check_val({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  // Main-instance byte scoreboard: a transfer is valid&&ready ahead of the next rising edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check_val("extra_byte", 32'(tx_data), 32'h100);
      else                   check_val("byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  // Repeat-instance scoreboard plus spacing between msg_done and the next line start.
  always @(negedge clk) begin
    if (rst_r) begin
      have_done <= 1'b0;
      prev_v_r  <= 1'b0;
    end else begin
      if (tx_valid_r && !prev_v_r && have_done)
        check_val("rep_gap", 32'(cyc - done_cyc), 32'd20);
      if (msg_done_r) begin
        done_cyc  <= cyc;
        have_done <= 1'b1;
      end
      if (tx_valid_r && tx_ready_r) begin
        if (exp_rq.size() == 0) check_val("rep_extra_byte", 32'(tx_data_r), 32'h100);
        else                    check_val("rep_byte", 32'(tx_data_r), 32'(exp_rq.pop_front()));
      end
      prev_v_r <= tx_valid_r;
    end
  end

  initial begin
    rst = 1'b1; rst_r = 1'b1;
    bcd1 = 4'd0; bcd0 = 4'd6; tx_ready = 1'b1;
    bcd1_r = 4'd4; bcd0_r = 4'd2; tx_ready_r = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(tx_valid), 32'd0);
    check_val("rst_data", 32'(tx_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(msg_done), 32'd0);

    // First line after reset, then silence while the value is constant.
    push_line(0, 4'd0, 4'd6);
    @(posedge clk); #1 rst = 1'b0;
    wait_done(0, "line06");
    repeat (30) @(negedge clk);
    check_val("quiet_q", 32'(exp_q.size()), 32'd0);
    check_val("quiet_busy", 32'(busy), 32'd0);

    // Backpressure during S_D0.
    push_line(0, 4'd2, 4'd6);
    @(posedge clk); #1 bcd1 = 4'd2; bcd0 = 4'd6;
    @(posedge clk);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", 32'(tx_valid), 32'd1);
      check_val("bp_data", 32'(tx_data), 32'h36);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_done(0, "bp");

    // Input change during S_CR: current line completes, then the new value.
    push_line(0, 4'd0, 4'd6);
    push_line(0, 4'd1, 4'd9);
    @(posedge clk); #1 bcd1 = 4'd0; bcd0 = 4'd6;
    repeat (3) @(posedge clk);
    #1 check_val("s_cr_data", 32'(tx_data), 32'h0D);
    bcd1 = 4'd1; bcd0 = 4'd9;
    wait_done(0, "chg_a");
    wait_done(0, "chg_b");

    // Non-decimal high digit.
    push_line(0, 4'hA, 4'd2);
    @(posedge clk); #1 bcd1 = 4'hA; bcd0 = 4'd2;
    wait_done(0, "inval");

    // Reset during S_D0 abandons the line; a full line follows release.
    exp_q.push_back(8'h30);
    @(posedge clk); #1 bcd1 = 4'd0; bcd0 = 4'd7;
    @(posedge clk);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check_val("mid_rst_valid", 32'(tx_valid), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_done", 32'(msg_done), 32'd0);
    check_val("mid_rst_data", 32'(tx_data), 32'd0);
    check_val("mid_rst_q", 32'(exp_q.size()), 32'd0);
    push_line(0, 4'd0, 4'd7);
    @(posedge clk); #1 rst = 1'b0;
    wait_done(0, "post_rst");

    // Periodic re-send on the REPEAT_CYCLES=20 instance.
    push_line(1, 4'd4, 4'd2);
    push_line(1, 4'd4, 4'd2);
    push_line(1, 4'd4, 4'd2);
    @(posedge clk); #1 rst_r = 1'b0;
    wait_done(1, "rep0");
    wait_done(1, "rep1");
    wait_done(1, "rep2");
    // Change lands on the same edge the repeat timer expires: exactly one line.
    push_line(1, 4'd4, 4'd3);
    repeat (19) @(posedge clk);
    #1 bcd0_r = 4'd3;
    wait_done(1, "coinc");
    repeat (15) @(negedge clk);
    check_val("rep_q", 32'(exp_rq.size()), 32'd0);
    check_val("rep_idle_valid", 32'(tx_valid_r), 32'd0);
    check_val("main_q", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1 rst_r = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_bcd_msg_sequencer.md
# uart_bcd_msg_sequencer

Message sequencer that sits between the two-digit BCD display value (`bcd1`, `bcd0`) and the byte-level UART transmitter. It snapshots the digit pair and formats it as a 4-byte ASCII line: digit1, digit0, CR, LF. It feeds that line byte-by-byte to the transmitter over a valid/ready handshake. A line is sent whenever the value differs from the last line sent, and optionally re-sent periodically.

## Interface
Parameters:
- `REPEAT_CYCLES`, default 0: idle cycles before re-sending an unchanged value. 0 disables periodic re-send.
- `CNT_W`, default 24: repeat counter width. Must satisfy `REPEAT_CYCLES < 2**CNT_W`.

Ports (one clock; `rst` is asynchronous and active-high):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bcd0`  in  4  low digit. Same clock domain, no synchronizer.
- `bcd1`  in  4  high digit.
- `tx_ready`  in  1  transmitter can accept a byte this cycle.
- `tx_valid`  out  1  `tx_data` holds a byte to transfer.
- `tx_data`  out  8  ASCII byte.
- `busy`  out  1  high while a line is in progress (not IDLE).
- `msg_done`  out  1  one-cycle pulse after the LF byte transfers.

## Operation
- States: IDLE, S_D1, S_D0, S_CR, S_LF.
- Transfer rule:
  - A byte transfers on a rising edge where `tx_valid && tx_ready`.
  - `tx_data` is stable while `tx_valid` is high and `tx_ready` is low.
  - `tx_valid` never drops without a transfer, except on reset.
- Trigger, evaluated only in IDLE; either condition starts a line:
  - Change: `{bcd1,bcd0}` differs from `last_sent`.
  - Repeat: `REPEAT_CYCLES` is nonzero and `rep_cnt == REPEAT_CYCLES-1`.
- On trigger:
  - Latch `snap <= {bcd1,bcd0}` and `last_sent <= {bcd1,bcd0}`.
  - Enter S_D1 with `tx_valid=1` and `tx_data=ascii(snap[7:4])`.
- Byte sequence. Each state advances only on a transfer:
  - S_D1 → S_D0, sending `ascii(snap[3:0])`.
  - S_D0 → S_CR, sending 0x0D.
  - S_CR → S_LF, sending 0x0A.
  - S_LF → IDLE: `tx_valid=0`, `tx_data=0x00`, `msg_done=1` for one cycle.
- Digit encoding `ascii(d)`:
  - d in 0..9 → 0x30+d.
  - d in 10..15 → 0x3F ('?').
- Input changes during a line do not affect bytes already in progress; only `snap` is used. If the value differs from `last_sent` on return to IDLE, the next line starts on the following trigger evaluation.
- `last_sent` resets to 0xFF, which no valid pair matches. This forces one line after reset, including for input 0x00.
- Repeat counter:
  - Increments every IDLE cycle, saturating at `REPEAT_CYCLES-1`.
  - Clears to 0 when leaving IDLE.
  - Stays 0 when `REPEAT_CYCLES==0`.
- When change and repeat coincide, exactly one line is sent.

## Timing
- Reset values: `tx_valid=0`, `tx_data=0x00`, `busy=0`, `msg_done=0`, state IDLE, `last_sent=0xFF`, `rep_cnt=0`, `snap=0x00`.
- All outputs are registered.
- Trigger latency: condition true before edge k → `tx_valid` and `busy` high after edge k.
- Throughput with `tx_ready` held high:
  - One byte per cycle; a line occupies 4 cycles of `tx_valid`.
  - `msg_done` pulses in the cycle after the LF transfer, with `busy=0` in that same cycle.
  - Earliest next `tx_valid` is one cycle after that.
- `rst` asserted mid-line:
  - All outputs go to reset values immediately (asynchronous); the partial line is abandoned.
  - After release, the full line is resent because `last_sent=0xFF`.

## Structure
- Package `uart_seq_pkg` holds:
  - State enum (IDLE, S_D1, S_D0, S_CR, S_LF).
  - Constants `ASCII_ZERO=8'h30`, `ASCII_QMARK=8'h3F`, `ASCII_CR=8'h0D`, `ASCII_LF=8'h0A`, `LAST_SENT_INIT=8'hFF`.
- One sub-module: `bcd_to_ascii` (combinational, 4-bit in → 8-bit out), instantiated twice or muxed by state.
- The UART bit-level transmitter stays a separate block connected through `tx_valid`/`tx_ready`/`tx_data`.

## Test plan
- Reset release with `bcd1=0`, `bcd0=6`, `tx_ready=1` → bytes 0x30, 0x36, 0x0D, 0x0A on 4 consecutive cycles, then a `msg_done` pulse; no further line while inputs stay constant (`REPEAT_CYCLES=0`).
- Backpressure: `tx_ready` low for 5 cycles during S_D0 → `tx_data` held at 0x36 with `tx_valid=1`; sequence resumes without loss or duplication.
- Change to `bcd1=1`, `bcd0=9` during S_CR of a 0x06 line → the current line completes as 30 36 0D 0A, then a second line 31 39 0D 0A follows.
- Invalid digit `bcd1=0xA`, `bcd0=2` → bytes 0x3F, 0x32, 0x0D, 0x0A.
- `REPEAT_CYCLES=20` with a constant value → lines start exactly 20 IDLE cycles after each `msg_done`; a coincident value change yields a single line.
- `rst` pulsed during S_D0 → `tx_valid`, `busy`, `msg_done` go to 0 immediately; after release a full line starting 0x30 is sent.
